// File: rtl/car_alarm_controller.sv
// rtl/car_alarm_controller.sv - car alarm FSM with exit/entry delays, timed siren and trigger-door latch
// Also registers the lights-left-on warning from the door, light and ignition sensors.
module car_alarm_controller #(
  parameter int NUM_DOORS   = 4,
  parameter int EXIT_DELAY  = 8,
  parameter int ENTRY_DELAY = 16,
  parameter int SIREN_TIME  = 64
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic [NUM_DOORS-1:0] DoorOpenSigns,
  input  logic                 CarLightsOnSign,
  input  logic                 IgnitionSignalOn,
  input  logic                 ArmRequest,
  input  logic                 DisarmRequest,
  output logic                 CarAlarmSignal,
  output logic                 LightsWarningSignal,
  output logic                 Armed,
  output logic [2:0]           StateCode,
  output logic [NUM_DOORS-1:0] TriggerDoor
);

  localparam int MaxExitEntry = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MaxDelay     = (MaxExitEntry > SIREN_TIME) ? MaxExitEntry : SIREN_TIME;
  localparam int CntW         = $clog2(MaxDelay + 1);

  localparam logic [CntW-1:0] ExitLoad  = CntW'(EXIT_DELAY - 1);
  localparam logic [CntW-1:0] EntryLoad = CntW'(ENTRY_DELAY - 1);
  localparam logic [CntW-1:0] SirenLoad = CntW'(SIREN_TIME - 1);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  state_t          state;
  logic [CntW-1:0] count;
  logic            anyDoorOpen;

  assign anyDoorOpen = |DoorOpenSigns;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state               <= DISARMED;
      count               <= '0;
      TriggerDoor         <= '0;
      LightsWarningSignal <= 1'b0;
    end else begin
      LightsWarningSignal <= CarLightsOnSign & anyDoorOpen & ~IgnitionSignalOn;
      if (DisarmRequest) begin
        state       <= DISARMED;
        count       <= '0;
        TriggerDoor <= '0;
      end else begin
        case (state)
          DISARMED: begin
            TriggerDoor <= '0;
            if (ArmRequest && !IgnitionSignalOn) begin
              state <= EXIT;
              count <= ExitLoad;
            end
          end
          EXIT: begin
            TriggerDoor <= '0;
            if (count == '0) begin
              // An open door at the end of the exit window restarts it.
              if (anyDoorOpen) count <= ExitLoad;
              else             state <= ARMED;
            end else begin
              count <= count - CntW'(1);
            end
          end
          ARMED: begin
            TriggerDoor <= TriggerDoor | DoorOpenSigns;
            if (IgnitionSignalOn) begin
              state <= ALARM;
              count <= SirenLoad;
            end else if (anyDoorOpen) begin
              state <= ENTRY;
              count <= EntryLoad;
            end
          end
          ENTRY: begin
            TriggerDoor <= TriggerDoor | DoorOpenSigns;
            if (IgnitionSignalOn || count == '0) begin
              state <= ALARM;
              count <= SirenLoad;
            end else begin
              count <= count - CntW'(1);
            end
          end
          ALARM: begin
            TriggerDoor <= TriggerDoor | DoorOpenSigns;
            if (count == '0) state <= anyDoorOpen ? LOCKOUT : ARMED;
            else             count <= count - CntW'(1);
          end
          LOCKOUT: begin
            TriggerDoor <= TriggerDoor | DoorOpenSigns;
            if (!anyDoorOpen) state <= ARMED;
          end
          default: begin
            state       <= DISARMED;
            count       <= '0;
            TriggerDoor <= '0;
          end
        endcase
      end
    end
  end

  assign CarAlarmSignal = (state == ALARM);
  assign Armed          = (state == ARMED) || (state == ENTRY) || (state == ALARM) || (state == LOCKOUT);
  assign StateCode      = state;

endmodule
